seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//   Parametrised time-multiplexed driver for a common-anode 7-segment display bank.
//   Successor to the fixed 4-digit, fixed-order scan in the FIFO demo top level.
//   Adds N digits, per-digit enable and decimal point, leading-zero blanking, PWM brightness
//   and a tear-free shadow register. Sits between user logic (hex nibbles) and board pins.
// PARAMETERS
//   G_NUM_DIGITS   8      digits driven, 1..8; digit 0 = rightmost
//   G_SUB_TICKS    12500  clocks per brightness sub-phase, >=2
//   G_BRIGHT_BITS  3      brightness resolution; slot = G_SUB_TICKS*2^G_BRIGHT_BITS clocks
//   G_ACTIVE_LOW   1      1: segments, DP and anodes active-low; 0: active-high
// PORTS
//   i_Clk          in   1                 system clock
//   i_Reset        in   1                 reset, synchronous, active-high
//   i_Digits       in   4*G_NUM_DIGITS    packed hex nibbles, [3:0] = digit 0
//   i_Digit_En     in   G_NUM_DIGITS      1 = digit lit, 0 = digit blank (segments and DP)
//   i_Dp           in   G_NUM_DIGITS      decimal point per digit
//   i_Lz_Blank     in   1                 1 = suppress leading zeros
//   i_Brightness   in   G_BRIGHT_BITS     on-time: (i_Brightness+1)/2^G_BRIGHT_BITS of slot
//   o_Segments     out  7                 bit0 = a ... bit6 = g
//   o_Dp           out  1                 decimal point
//   o_Anode        out  G_NUM_DIGITS      digit select, at most one active
//   o_Frame_Start  out  1                 1-cycle pulse at each shadow capture
// BEHAVIOUR
// - One clock (i_Clk); reset is synchronous and active-high on i_Reset. Reset overrides all.
// - Reset values: counters and digit index = 0; shadow regs = 0.
//   o_Anode, o_Segments and o_Dp all inactive (all 1s when G_ACTIVE_LOW=1); o_Frame_Start = 0.
// - Counters: tick 0..G_SUB_TICKS-1; phase 0..2^B-1 advances on tick wrap.
//   Digit index advances on phase wrap; wraps from G_NUM_DIGITS-1 to 0.
//   Scan order is 0,1,..,N-1. With N=1 the index stays at 0.
// - Frame tick: the cycle with tick=phase=index=0. This includes the first cycle after reset
//   deasserts. In that cycle, i_Digits, i_Digit_En, i_Dp, i_Lz_Blank and i_Brightness are
//   copied into shadow regs, and o_Frame_Start=1. No other cycle touches the shadow.
//   Input changes mid-frame are invisible until the next frame.
// - Pipeline: stage 1 registers {index, phase, decoded segments of shadow digit}.
//   Stage 2 registers the outputs. Outputs lag the counter state by exactly 2 cycles:
//   digit k is presented for the whole slot shifted by +2 cycles.
// - Anode k is active iff index==k and phase <= shadow brightness and shadow en[k]==1.
//   Brightness max gives 100% on-time; brightness 0 gives 1/2^B.
// - Segments: hex decode 0-F (b and d lowercase).
//   Segments are inactive whenever the anode is inactive, giving ghost-free switching.
// - Leading-zero blank (shadow lz=1): digit k>0 is blanked if its nibble==0 and every enabled
//   digit above k has nibble==0. Disabled digits are ignored in this chain.
//   Digit 0 is never LZ-blanked. DP stays driven on an LZ-blanked digit if dp[k]=1.
// - Polarity: logical active-high internally; inversion at the output register
//   when G_ACTIVE_LOW=1.
// - Reset mid-scan: outputs are inactive on the next cycle; the scan restarts at digit 0
//   with a frame tick.
// STRUCTURE
// - seven_seg_pkg: hex-to-segment constant table, SEG_OFF, G_NUM_DIGITS max (8),
//   and segment bit-index constants.
// - Sub-module seven_seg_hex_decode: combinational nibble -> 7 bits, active-high.
//   Single instance on the muxed shadow digit.
// TESTING  (G_NUM_DIGITS=4, G_SUB_TICKS=4, G_BRIGHT_BITS=2, G_ACTIVE_LOW=1:
//           slot=16, frame=64 clocks)
// 1. Hold i_Reset 3 cycles -> o_Anode=4'hF, o_Segments=7'h7F, o_Dp=1.
//    Release -> o_Frame_Start pulses in the 1st cycle, then every 64 cycles.
// 2. i_Digits=16'h12AF, en=4'hF, bright=3, lz=0:
//    digit0: o_Anode=4'b1110, o_Segments=7'h0E ('F').
//    digit1: 7'h08 ('A').
//    digit3: 7'h79 ('1').
//    Each anode is active 16 clocks, starting at slot start +2.
// 3. bright=0 -> each anode active 4 of 16 clocks (phase 0 only).
//    bright=2 -> 12 of 16. The segments track the anode.
// 4. lz=1, i_Digits=16'h0050 -> digits 3 and 2 dark; digit1 shows '5'; digit0 shows '0'.
//    16'h0000 -> only digit0 lit.
//    en=4'b0111 with 16'h1050 -> digit2 dark (LZ), digit3 dark (disabled).
// 5. Change i_Digits at mid-frame (cycle 30) -> outputs unchanged until frame tick +2.
// 6. Assert i_Reset while digit 2 is lit -> outputs inactive next cycle.
//    After release, the scan restarts at digit 0 with o_Frame_Start.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module   : seven_seg_pkg
// Brief    : Shared constants for the multiplexed 7-segment display driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seven_seg_pkg;

   localparam int C_MAX_DIGITS = 8;

   localparam int C_SEG_A = 0;
   localparam int C_SEG_B = 1;
   localparam int C_SEG_C = 2;
   localparam int C_SEG_D = 3;
   localparam int C_SEG_E = 4;
   localparam int C_SEG_F = 5;
   localparam int C_SEG_G = 6;

   localparam logic [6:0] C_SEG_OFF = 7'h00;

   // Active-high patterns, bit0 = a ... bit6 = g; entry 15 listed first
   localparam logic [15:0][6:0] C_SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

`default_nettype wire

// File: rtl/seven_seg_hex_decode.sv
// ============================================================================
// Module   : seven_seg_hex_decode
// Brief    : Combinational hex nibble to active-high 7-segment pattern.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seven_seg_hex_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_segments
);

   assign o_segments = C_SEG_TABLE[i_nibble];

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Brief    : N-digit scanned 7-segment driver with PWM, LZ blanking, shadow regs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int G_NUM_DIGITS  = 8,
   parameter int G_SUB_TICKS   = 12500,
   parameter int G_BRIGHT_BITS = 3,
   parameter int G_ACTIVE_LOW  = 1
)(
   input  logic                        i_Clk,
   input  logic                        i_Reset,
   input  logic [4*G_NUM_DIGITS-1:0]   i_Digits,
   input  logic [G_NUM_DIGITS-1:0]     i_Digit_En,
   input  logic [G_NUM_DIGITS-1:0]     i_Dp,
   input  logic                        i_Lz_Blank,
   input  logic [G_BRIGHT_BITS-1:0]    i_Brightness,
   output logic [6:0]                  o_Segments,
   output logic                        o_Dp,
   output logic [G_NUM_DIGITS-1:0]     o_Anode,
   output logic                        o_Frame_Start
);

   localparam int   C_IDX_W  = (G_NUM_DIGITS > 1) ? $clog2(G_NUM_DIGITS) : 1;
   localparam int   C_TICK_W = $clog2(G_SUB_TICKS);
   localparam logic C_INV    = (G_ACTIVE_LOW != 0);

   logic [C_TICK_W-1:0]       r_tick;
   logic [G_BRIGHT_BITS-1:0]  r_phase;
   logic [C_IDX_W-1:0]        r_index;
   logic                      w_tick_wrap;
   logic                      w_phase_wrap;
   logic                      w_frame;

   assign w_tick_wrap  = (r_tick == C_TICK_W'(G_SUB_TICKS - 1));
   assign w_phase_wrap = w_tick_wrap && (r_phase == '1);
   assign w_frame      = !i_Reset && (r_tick == '0) && (r_phase == '0) && (r_index == '0);
   assign o_Frame_Start = w_frame;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_tick  <= '0;
         r_phase <= '0;
         r_index <= '0;
      end else begin
         r_tick <= w_tick_wrap ? '0 : r_tick + C_TICK_W'(1);
         if (w_tick_wrap)
            r_phase <= r_phase + G_BRIGHT_BITS'(1);
         if (w_phase_wrap)
            r_index <= (r_index == C_IDX_W'(G_NUM_DIGITS - 1)) ? '0 : r_index + C_IDX_W'(1);
      end
   end

   logic [4*G_NUM_DIGITS-1:0]  r_sh_digits;
   logic [G_NUM_DIGITS-1:0]    r_sh_en;
   logic [G_NUM_DIGITS-1:0]    r_sh_dp;
   logic                       r_sh_lz;
   logic [G_BRIGHT_BITS-1:0]   r_sh_bright;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_sh_digits <= '0;
         r_sh_en     <= '0;
         r_sh_dp     <= '0;
         r_sh_lz     <= 1'b0;
         r_sh_bright <= '0;
      end else if (w_frame) begin
         r_sh_digits <= i_Digits;
         r_sh_en     <= i_Digit_En;
         r_sh_dp     <= i_Dp;
         r_sh_lz     <= i_Lz_Blank;
         r_sh_bright <= i_Brightness;
      end
   end

   // The frame-tick cycle itself must already see the new frame's values
   logic [4*G_NUM_DIGITS-1:0]  w_digits;
   logic [G_NUM_DIGITS-1:0]    w_en;
   logic [G_NUM_DIGITS-1:0]    w_dp;
   logic                       w_lz;
   logic [G_BRIGHT_BITS-1:0]   w_bright;

   assign w_digits = w_frame ? i_Digits     : r_sh_digits;
   assign w_en     = w_frame ? i_Digit_En   : r_sh_en;
   assign w_dp     = w_frame ? i_Dp         : r_sh_dp;
   assign w_lz     = w_frame ? i_Lz_Blank   : r_sh_lz;
   assign w_bright = w_frame ? i_Brightness : r_sh_bright;

   logic [G_NUM_DIGITS-1:0] w_lz_blank;

   // Walk from the most significant digit down; disabled digits do not break the zero run
   always_comb begin : p_lz
      logic zero_above;
      zero_above = 1'b1;
      w_lz_blank = '0;
      for (int k = G_NUM_DIGITS - 1; k >= 0; k--) begin
         w_lz_blank[k] = w_lz && (k != 0) && (w_digits[4*k +: 4] == 4'h0) && zero_above;
         if (w_en[k] && (w_digits[4*k +: 4] != 4'h0))
            zero_above = 1'b0;
      end
   end

   logic [3:0] w_nib;
   logic [6:0] w_seg_dec;

   assign w_nib = w_digits[4*r_index +: 4];

   seven_seg_hex_decode u_hex_decode (
      .i_nibble   (w_nib),
      .o_segments (w_seg_dec)
   );

   logic [C_IDX_W-1:0] r1_index;
   logic               r1_on;
   logic               r1_blank;
   logic               r1_dp;
   logic [6:0]         r1_seg;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r1_index <= '0;
         r1_on    <= 1'b0;
         r1_blank <= 1'b0;
         r1_dp    <= 1'b0;
         r1_seg   <= C_SEG_OFF;
      end else begin
         r1_index <= r_index;
         r1_on    <= (r_phase <= w_bright) && w_en[r_index];
         r1_blank <= w_lz_blank[r_index];
         r1_dp    <= w_dp[r_index];
         r1_seg   <= w_seg_dec;
      end
   end

   logic [G_NUM_DIGITS-1:0] w_anode;
   logic [6:0]              w_seg;
   logic                    w_dp_out;

   always_comb begin
      w_anode = '0;
      if (r1_on)
         w_anode[r1_index] = 1'b1;
      w_seg    = (r1_on && !r1_blank) ? r1_seg : C_SEG_OFF;
      w_dp_out = r1_on && r1_dp;
   end

   logic [G_NUM_DIGITS-1:0] r_anode;
   logic [6:0]              r_seg;
   logic                    r_dp;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_anode <= {G_NUM_DIGITS{C_INV}};
         r_seg   <= {7{C_INV}};
         r_dp    <= C_INV;
      end else begin
         r_anode <= w_anode ^ {G_NUM_DIGITS{C_INV}};
         r_seg   <= w_seg ^ {7{C_INV}};
         r_dp    <= w_dp_out ^ C_INV;
      end
   end

   assign o_Anode    = r_anode;
   assign o_Segments = r_seg;
   assign o_Dp       = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Brief    : Directed self-checking bench, 4 digits, slot 16 / frame 64 clocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  en;
   logic [3:0]  dp;
   logic        lz;
   logic [1:0]  bright;
   logic [6:0]  seg;
   logic        dp_o;
   logic [3:0]  anode;
   logic        fs;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(
      .G_NUM_DIGITS  (4),
      .G_SUB_TICKS   (4),
      .G_BRIGHT_BITS (2),
      .G_ACTIVE_LOW  (1)
   ) dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Digits      (digits),
      .i_Digit_En    (en),
      .i_Dp          (dp),
      .i_Lz_Blank    (lz),
      .i_Brightness  (bright),
      .o_Segments    (seg),
      .o_Dp          (dp_o),
      .o_Anode       (anode),
      .o_Frame_Start (fs)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s @cyc%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] a, input logic [6:0] s,
                          input logic d);
      chk({tag, ".anode"}, {28'd0, anode}, {28'd0, a});
      chk({tag, ".seg"},   {25'd0, seg},   {25'd0, s});
      chk({tag, ".dp"},    {31'd0, dp_o},  {31'd0, d});
   endtask

   task automatic step_to(input int n);
      while (cyc < n) begin
         @(negedge clk);
         cyc++;
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst    = 1'b1;
      digits = 16'h12AF;
      en     = 4'hF;
      dp     = 4'b0010;
      lz     = 1'b0;
      bright = 2'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk_out("reset", 4'hF, 7'h7F, 1'b1);
      chk("reset.fs", {31'd0, fs}, 32'd0);

      // Release: this cycle is the first frame tick
      rst = 1'b0;
      cyc = 0;
      #1;
      chk("fs0", {31'd0, fs}, 32'd1);
      step_to(1);
      chk("fs1", {31'd0, fs}, 32'd0);
      chk("idle1.anode", {28'd0, anode}, 32'hF);

      step_to(2);
      chk_out("d0_F", 4'b1110, 7'h0E, 1'b1);
      step_to(17);
      chk_out("d0_F_end", 4'b1110, 7'h0E, 1'b1);
      step_to(18);
      chk_out("d1_A", 4'b1101, 7'h08, 1'b0);
      step_to(34);
      chk_out("d2_2", 4'b1011, 7'h24, 1'b1);
      step_to(50);
      chk_out("d3_1", 4'b0111, 7'h79, 1'b1);
      step_to(63);
      chk("fs63", {31'd0, fs}, 32'd0);
      step_to(64);
      chk("fs64", {31'd0, fs}, 32'd1);
      step_to(65);
      chk_out("d3_tail", 4'b0111, 7'h79, 1'b1);
      step_to(66);
      chk_out("d0_f1", 4'b1110, 7'h0E, 1'b1);

      // Brightness 0 from frame 2
      step_to(70);
      bright = 2'd0;
      step_to(126);
      chk_out("f1_full_bright", 4'b0111, 7'h79, 1'b1);
      step_to(128);
      chk("fs128", {31'd0, fs}, 32'd1);
      step_to(133);
      chk_out("b0_on", 4'b1110, 7'h0E, 1'b1);
      step_to(134);
      chk_out("b0_off", 4'b1111, 7'h7F, 1'b1);
      step_to(146);
      chk_out("b0_d1", 4'b1101, 7'h08, 1'b0);

      // Brightness 2 from frame 3
      step_to(140);
      bright = 2'd2;
      step_to(205);
      chk_out("b2_on", 4'b1110, 7'h0E, 1'b1);
      step_to(206);
      chk_out("b2_off", 4'b1111, 7'h7F, 1'b1);
      step_to(210);
      chk_out("b2_d1", 4'b1101, 7'h08, 1'b0);

      // Leading-zero blanking from frame 4
      step_to(200);
      bright = 2'd3;
      lz     = 1'b1;
      digits = 16'h0050;
      dp     = 4'b1000;
      step_to(258);
      chk_out("lz_d0", 4'b1110, 7'h40, 1'b1);
      step_to(274);
      chk_out("lz_d1", 4'b1101, 7'h12, 1'b1);
      step_to(290);
      chk_out("lz_d2", 4'b1011, 7'h7F, 1'b1);
      step_to(306);
      chk_out("lz_d3_dp", 4'b0111, 7'h7F, 1'b0);

      step_to(300);
      digits = 16'h0000;
      step_to(322);
      chk_out("zero_d0", 4'b1110, 7'h40, 1'b1);
      step_to(338);
      chk_out("zero_d1", 4'b1101, 7'h7F, 1'b1);

      step_to(350);
      digits = 16'h1050;
      en     = 4'b0111;
      dp     = 4'b0000;
      step_to(402);
      chk_out("dis_d1", 4'b1101, 7'h12, 1'b1);
      step_to(418);
      chk_out("dis_d2", 4'b1011, 7'h7F, 1'b1);
      step_to(434);
      chk_out("dis_d3", 4'b1111, 7'h7F, 1'b1);

      // Mid-frame change in frame 7 stays invisible until frame 8
      step_to(440);
      digits = 16'h12AF;
      en     = 4'hF;
      lz     = 1'b0;
      step_to(478);
      digits = 16'h8888;
      step_to(496);
      chk_out("mid_d2", 4'b1011, 7'h24, 1'b1);
      step_to(513);
      chk_out("mid_d3", 4'b0111, 7'h79, 1'b1);
      step_to(514);
      chk_out("new_d0", 4'b1110, 7'h00, 1'b1);

      // Reset while digit 2 is lit
      step_to(550);
      chk_out("pre_rst_d2", 4'b1011, 7'h00, 1'b1);
      rst = 1'b1;
      step_to(551);
      chk_out("mid_rst", 4'b1111, 7'h7F, 1'b1);
      chk("mid_rst.fs", {31'd0, fs}, 32'd0);
      rst = 1'b0;
      #1;
      chk("restart.fs", {31'd0, fs}, 32'd1);
      step_to(552);
      chk_out("restart_idle", 4'b1111, 7'h7F, 1'b1);
      step_to(553);
      chk_out("restart_d0", 4'b1110, 7'h00, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
